// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: two Avalon-MM masters (m0 = instruction fetch,
// m1 = data) sharing one Avalon-MM slave. Requests are serialised through
// an IDLE -> ISSUE -> WAIT -> DONE sequence. The slave command is
// registered, and the granted master sees waitrequest low for exactly one
// cycle, in DONE, with its readdata already registered.
// Optional build macro ARB_ROUND_ROBIN_EN: on a simultaneous request the
// master that did not win last time is granted. Without it the fixed
// priority set by PRIO_M1 always applies.
module avalon_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRIO_M1 = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    // grant: 0 = m0, 1 = m1; only meaningful outside IDLE
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   s_address_q, s_address_d;
    logic [BE_W-1:0]     s_byteenable_q, s_byteenable_d;
    logic [DATA_W-1:0]   s_writedata_q, s_writedata_d;
    logic                s_read_q, s_read_d;
    logic                s_write_q, s_write_d;
    logic [DATA_W-1:0]   m0_readdata_q, m0_readdata_d;
    logic [DATA_W-1:0]   m1_readdata_q, m1_readdata_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_grant_q, last_grant_d;
`endif

    logic req0, req1, winner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Arbitration: pick which master is granted when leaving IDLE
    always_comb begin
        winner = req1;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~last_grant_q;
`else
            winner = (PRIO_M1 != 0);
`endif
        end
    end

    // State register plus registered slave command and readdata; reset
    // clears the slave command asynchronously, abandoning any transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            s_address_q    <= '0;
            s_byteenable_q <= '0;
            s_writedata_q  <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            m0_readdata_q  <= '0;
            m1_readdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q   <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            s_address_q    <= s_address_d;
            s_byteenable_q <= s_byteenable_d;
            s_writedata_q  <= s_writedata_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            m0_readdata_q  <= m0_readdata_d;
            m1_readdata_q  <= m1_readdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    // Next-state logic; waitrequest is ignored in ISSUE because the slave
    // only raises it in response to the command edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 || req1) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (!s_waitrequest) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of grant, slave command and per-master readdata
    always_comb begin
        grant_d        = grant_q;
        s_address_d    = s_address_q;
        s_byteenable_d = s_byteenable_q;
        s_writedata_d  = s_writedata_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        m0_readdata_d  = m0_readdata_q;
        m1_readdata_d  = m1_readdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d   = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d        = winner;
                    s_address_d    = winner ? m1_address    : m0_address;
                    s_byteenable_d = winner ? m1_byteenable : m0_byteenable;
                    s_writedata_d  = winner ? m1_writedata  : m0_writedata;
                    // read and write together is treated as a write
                    s_write_d      = winner ? m1_write : m0_write;
                    s_read_d       = winner ? (m1_read & ~m1_write)
                                            : (m0_read & ~m0_write);
                end
            end
            WAIT: begin
                if (!s_waitrequest) begin
                    if (s_read_q) begin
                        if (grant_q) m1_readdata_d = s_readdata;
                        else         m0_readdata_d = s_readdata;
                    end
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                end
            end
            DONE: begin
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_d = grant_q;
`endif
            end
            default: ;
        endcase
    end

    // Per-master stall: released only in DONE for the granted master
    always_comb begin
        m0_waitrequest = req0 & ~((state_q == DONE) && (grant_q == 1'b0));
        m1_waitrequest = req1 & ~((state_q == DONE) && (grant_q == 1'b1));
    end

    assign s_address    = s_address_q;
    assign s_byteenable = s_byteenable_q;
    assign s_writedata  = s_writedata_q;
    assign s_read       = s_read_q;
    assign s_write      = s_write_q;
    assign m0_readdata  = m0_readdata_q;
    assign m1_readdata  = m1_readdata_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: a 16-word slave RAM with a
// configurable wait count, and a transaction-level reference model that
// predicts arbitration order, completion cycle, memory contents and readdata.
module tb_avalon_mem_arbiter;

    localparam int PRIO = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_address, m0_writedata, m0_readdata;
    logic [3:0]  m0_byteenable;
    logic        m0_read, m0_write, m0_waitrequest;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic [3:0]  m1_byteenable;
    logic        m1_read, m1_write, m1_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic [3:0]  s_byteenable;
    logic        s_read, s_write, s_waitrequest;

    int total = 0;
    int bad   = 0;

    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    bit          slv_init = 1'b0;
    int          scyc = 0;
    int          slv_wait = 0;
    logic [31:0] exp_rd [2];
    int          model_last = 1;

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_M1(PRIO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h12345678;
        if (i == 4) return 32'h0;
        return 32'hA5000000 | (i * 32'h00010203);
    endfunction

    // Slave RAM: waitrequest high on the command edge and for slv_wait
    // further cycles, then the transfer completes
    always @(posedge clk) begin
        if (!slv_init) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
            slv_init <= 1'b1;
        end else if (s_write && !s_waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (s_byteenable[b]) slv_mem[s_address[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
        end
        scyc <= (s_read || s_write) ? scyc + 1 : 0;
    end

    assign s_waitrequest = (s_read || s_write) && (scyc <= slv_wait);
    assign s_readdata    = slv_mem[s_address[5:2]];

    // Reference memory: op 0 = read (returns word), 1 = write, 2 = read+write (acts as write)
    function automatic logic [31:0] ref_apply(input int op, input logic [31:0] a,
                                              input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w;
        w = ref_mem[a[5:2]];
        if (op == 0) return w;
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a[5:2]] = w;
        return 32'h0;
    endfunction

    function automatic int pick_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return (model_last == 1) ? 0 : 1;
`else
        return PRIO;
`endif
    endfunction

    function automatic logic wreq(input int x);
        return (x == 1) ? m1_waitrequest : m0_waitrequest;
    endfunction

    function automatic logic [31:0] rdata(input int x);
        return (x == 1) ? m1_readdata : m0_readdata;
    endfunction

    task automatic drop(input int x);
        if (x == 1) begin m1_read = 1'b0; m1_write = 1'b0; end
        else        begin m0_read = 1'b0; m0_write = 1'b0; end
    endtask

    task automatic idle_masters();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    endtask

    // One scenario: either or both masters issue one transfer each
    task automatic run_pair(input bit en0, input int op0, input logic [31:0] a0,
                            input logic [3:0] be0, input logic [31:0] wd0,
                            input bit en1, input int op1, input logic [31:0] a1,
                            input logic [3:0] be1, input logic [31:0] wd1,
                            input int wt, input string nm);
        bit          en [2];
        int          op [2];
        logic [31:0] a [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        int          exp_done [2];
        int          got_done [2];
        logic [31:0] exp_data [2];
        bit          done [2];
        int          win, los, cmd_cyc, addr_bad, gap_bad;
        en[0] = en0; op[0] = op0; a[0] = a0; be[0] = be0; wd[0] = wd0;
        en[1] = en1; op[1] = op1; a[1] = a1; be[1] = be1; wd[1] = wd1;
        exp_done[0] = 0; exp_done[1] = 0; got_done[0] = 0; got_done[1] = 0;
        done[0] = 0; done[1] = 0; exp_data[0] = 0; exp_data[1] = 0;
        cmd_cyc = 0; addr_bad = 0; gap_bad = 0;
        win = (en0 && en1) ? pick_winner() : (en1 ? 1 : 0);
        los = 1 - win;
        exp_done[win] = 4 + wt;
        exp_data[win] = ref_apply(op[win], a[win], be[win], wd[win]);
        if (op[win] == 0) exp_rd[win] = exp_data[win];
        model_last = win;
        if (en[los]) begin
            exp_done[los] = 8 + 2 * wt;
            exp_data[los] = ref_apply(op[los], a[los], be[los], wd[los]);
            if (op[los] == 0) exp_rd[los] = exp_data[los];
            model_last = los;
        end
        slv_wait = wt;
        @(negedge clk);
        m0_address = a0; m0_byteenable = be0; m0_writedata = wd0;
        m0_read = en0 && (op0 != 1); m0_write = en0 && (op0 != 0);
        m1_address = a1; m1_byteenable = be1; m1_writedata = wd1;
        m1_read = en1 && (op1 != 1); m1_write = en1 && (op1 != 0);
        for (int k = 1; k <= 80; k++) begin
            #1;
            if (s_read || s_write) begin
                cmd_cyc++;
                if (s_address !== ((k <= exp_done[win]) ? a[win] : a[los])) addr_bad++;
            end
            if (en0 && en1 && k == exp_done[win] + 1 && (s_read || s_write)) gap_bad++;
            for (int x = 0; x < 2; x++) begin
                if (!en[x] && k == 1) begin
                    total++;
                    if (wreq(x) !== 1'b0) begin
                        bad++;
                        $display("FAIL %s idle m%0d waitrequest got=%b want=0", nm, x, wreq(x));
                    end
                end
                if (en[x] && !done[x] && wreq(x) === 1'b0) begin
                    done[x] = 1; got_done[x] = k;
                    if (op[x] == 0) begin
                        total++;
                        if (rdata(x) !== exp_data[x]) begin
                            bad++;
                            $display("FAIL %s m%0d readdata got=%h want=%h", nm, x, rdata(x), exp_data[x]);
                        end
                    end
                    drop(x);
                end
            end
            if ((done[0] || !en[0]) && (done[1] || !en[1])) break;
            @(negedge clk);
        end
        for (int x = 0; x < 2; x++) begin
            if (en[x]) begin
                total++;
                if (got_done[x] !== exp_done[x]) begin
                    bad++;
                    $display("FAIL %s m%0d completion cycle got=%0d want=%0d", nm, x, got_done[x], exp_done[x]);
                end
            end
            total++;
            if (rdata(x) !== exp_rd[x]) begin
                bad++;
                $display("FAIL %s m%0d readdata hold got=%h want=%h", nm, x, rdata(x), exp_rd[x]);
            end
        end
        total++;
        if (cmd_cyc !== (int'(en0) + int'(en1)) * (2 + wt)) begin
            bad++;
            $display("FAIL %s slave command cycles got=%0d want=%0d", nm, cmd_cyc,
                     (int'(en0) + int'(en1)) * (2 + wt));
        end
        total++;
        if (addr_bad !== 0) begin
            bad++;
            $display("FAIL %s slave address cycles wrong got=%0d want=0", nm, addr_bad);
        end
        if (en0 && en1) begin
            total++;
            if (gap_bad !== 0) begin
                bad++;
                $display("FAIL %s idle gap command got=%0d want=0", nm, gap_bad);
            end
        end
    endtask

    task automatic test_reset();
        idle_masters();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({s_read, s_write, s_address, s_byteenable, s_writedata} !== '0) begin
            bad++;
            $display("FAIL reset slave outputs got=%b/%b/%h/%h/%h want=0", s_read, s_write,
                     s_address, s_byteenable, s_writedata);
        end
        total++;
        if ({m0_readdata, m1_readdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset readdata got=%h/%h want=0", m0_readdata, m1_readdata);
        end
        total++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b00) begin
            bad++;
            $display("FAIL reset waitrequest got=%b%b want=00", m0_waitrequest, m1_waitrequest);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd[0] = 0; exp_rd[1] = 0; model_last = 1;
    endtask

    task automatic test_single_read();
        run_pair(1, 0, 32'hBFC00000, 4'hF, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, "single_read");
    endtask

    task automatic test_write_read();
        run_pair(0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'hBFC00010, 4'b0011, 32'hDEADBEEF, 0, "m1_write");
        run_pair(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'hBFC00010, 4'hF, 32'h0, 0, "m1_readback");
        total++;
        if (m1_readdata !== 32'h0000BEEF) begin
            bad++;
            $display("FAIL write_read m1 readdata got=%h want=0000beef", m1_readdata);
        end
    endtask

    task automatic test_simultaneous();
        run_pair(1, 0, 32'hBFC00008, 4'hF, 32'h0, 1, 0, 32'hBFC0000C, 4'hF, 32'h0, 0, "simultaneous");
    endtask

    task automatic test_long_wait();
        run_pair(1, 0, 32'hBFC00014, 4'hF, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 5, "long_wait");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_pair(1, 0, 32'hBFC00000 | (i << 2), 4'hF, 32'h0,
                     1, 0, 32'hBFC00020 | (i << 2), 4'hF, 32'h0, 0, "back_to_back");
    endtask

    task automatic test_random();
        bit e0, e1;
        for (int i = 0; i < 20; i++) begin
            e0 = 1'($urandom_range(1));
            e1 = 1'($urandom_range(1));
            if (!e0 && !e1) e1 = 1'b1;
            run_pair(e0, int'($urandom_range(2)), 32'hBFC00000 | (32'($urandom_range(15)) << 2),
                     4'($urandom), $urandom,
                     e1, int'($urandom_range(2)), 32'hBFC00000 | (32'($urandom_range(15)) << 2),
                     4'($urandom), $urandom, int'($urandom_range(3)), "random");
        end
    endtask

    task automatic test_reset_mid();
        slv_wait = 5;
        @(negedge clk);
        m0_address = 32'hBFC00018; m0_byteenable = 4'hF; m0_read = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (s_read !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid s_read before reset got=%b want=1", s_read);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({s_read, s_write, s_address} !== '0) begin
            bad++;
            $display("FAIL reset_mid slave command got=%b/%b/%h want=0", s_read, s_write, s_address);
        end
        total++;
        if ({m0_readdata, m1_readdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid readdata got=%h/%h want=0", m0_readdata, m1_readdata);
        end
        m0_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd[0] = 0; exp_rd[1] = 0; model_last = 1;
        run_pair(1, 0, 32'hBFC00018, 4'hF, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        exp_rd[0] = 0; exp_rd[1] = 0;
        test_reset();
        test_single_read();
        test_write_read();
        test_simultaneous();
        test_long_wait();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
